// File: rtl/int2fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int2fp_pkg
// Brief    : Shared binary32 field widths, packed layouts and helpers for the
//            integer-to-fp32 conversion pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package int2fp_pkg;

    localparam int FP32_E_WIDTH = 8;
    localparam int FP32_M_WIDTH = 23;
    localparam int FP32_BIAS    = 127;

    typedef struct packed {
        logic                    sign;
        logic [FP32_E_WIDTH-1:0] exp;
        logic [FP32_M_WIDTH-1:0] man;
    } fp32_t;

    // Final-stage payload: packed result plus its rounding status.
    typedef struct packed {
        fp32_t data;
        logic  inexact;
    } s3_payload_t;

    function automatic fp32_t fp32_pack(
        input logic                    sign,
        input logic [FP32_E_WIDTH-1:0] exp,
        input logic [FP32_M_WIDTH-1:0] man
    );
        fp32_t r;
        r.sign = sign;
        r.exp  = exp;
        r.man  = man;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msb_index_detect.sv
`default_nettype none
// ============================================================================
// Module   : msb_index_detect
// Brief    : Combinational leading-one detector; returns the bit position of
//            the highest set bit and a zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module msb_index_detect #(
    parameter int INT_WIDTH = 32,
    parameter int IDX_WIDTH = $clog2(INT_WIDTH)
) (
    input  logic [INT_WIDTH-1:0] i_data,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_zero
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < INT_WIDTH; i++) begin
            if (i_data[i]) begin
                o_idx = IDX_WIDTH'(i);
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule
`default_nettype wire

// File: rtl/int_to_fp32_pipe.sv
`default_nettype none
// ============================================================================
// Module   : int_to_fp32_pipe
// Brief    : Three-stage signed/unsigned integer to IEEE-754 binary32
//            converter with valid/ready backpressure and an inexact flag.
//            Define INT2FP_RNE_EN for round-to-nearest-even; otherwise the
//            mantissa is truncated toward zero.
// Revision : 1.0 - initial release
// ============================================================================
module int_to_fp32_pipe
    import int2fp_pkg::*;
#(
    parameter int INT_WIDTH = 32,
    parameter int IDX_WIDTH = $clog2(INT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INT_WIDTH-1:0] in_data,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic                 out_inexact
);

    generate
        if (INT_WIDTH < 8 || INT_WIDTH > 64) begin : g_bad_width
            $error("int_to_fp32_pipe: INT_WIDTH must be within 8..64");
        end
        if (IDX_WIDTH != $clog2(INT_WIDTH)) begin : g_bad_idx_width
            $error("int_to_fp32_pipe: IDX_WIDTH is derived and must not be overridden");
        end
    endgenerate

    // Leading one is dropped, so the aligned fraction carries mantissa,
    // guard and sticky bits below it.
    localparam int c_EXT_WIDTH = INT_WIDTH + FP32_M_WIDTH + 1;
    localparam int c_GUARD_BIT = c_EXT_WIDTH - 2 - FP32_M_WIDTH;

    typedef struct packed {
        logic                 sign;
        logic                 zero;
        logic [INT_WIDTH-1:0] mag;
    } s1_payload_t;

    typedef struct packed {
        logic                 sign;
        logic                 zero;
        logic [IDX_WIDTH-1:0] idx;
        logic [INT_WIDTH-1:0] mag;
    } s2_payload_t;

    logic        w_en;
    logic        r_s1_valid;
    logic        r_s2_valid;
    logic        r_out_valid;
    s1_payload_t r_s1;
    s2_payload_t r_s2;
    s3_payload_t r_out;
    s1_payload_t w_s1_next;
    s2_payload_t w_s2_next;
    s3_payload_t w_s3_next;

    logic [IDX_WIDTH-1:0]    w_det_idx;
    logic                    w_det_zero;
    logic [IDX_WIDTH-1:0]    w_lshift;
    logic [c_EXT_WIDTH-2:0]  w_frac;
    logic [FP32_M_WIDTH-1:0] w_man_trunc;
    logic [FP32_M_WIDTH-1:0] w_man;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_round_up;
    logic                    w_carry;
    logic [FP32_E_WIDTH-1:0] w_exp;

    // A single enable freezes the whole pipe when the output is blocked.
    assign w_en     = !r_out_valid | out_ready;
    assign in_ready = w_en;

    // Stage 1: sign and magnitude.
    always_comb begin
        w_s1_next      = '0;
        w_s1_next.sign = in_signed & in_data[INT_WIDTH-1];
        w_s1_next.mag  = w_s1_next.sign ? -in_data : in_data;
        w_s1_next.zero = (in_data == '0);
    end

    // Stage 2: leading-one position.
    msb_index_detect #(
        .INT_WIDTH (INT_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_msb_index_detect (
        .i_data (r_s1.mag),
        .o_idx  (w_det_idx),
        .o_zero (w_det_zero)
    );

    always_comb begin
        w_s2_next      = '0;
        w_s2_next.sign = r_s1.sign;
        // The two zero indications always agree; either forces a +0 result.
        w_s2_next.zero = r_s1.zero | w_det_zero;
        w_s2_next.idx  = w_det_idx;
        w_s2_next.mag  = r_s1.mag;
    end

    // Stage 3: left-align, round and pack.
    assign w_lshift    = IDX_WIDTH'(INT_WIDTH - 1) - r_s2.idx;
    assign w_frac      = (c_EXT_WIDTH-1)'({r_s2.mag, {(FP32_M_WIDTH+1){1'b0}}} << w_lshift);
    assign w_man_trunc = w_frac[c_EXT_WIDTH-2 -: FP32_M_WIDTH];
    assign w_guard     = w_frac[c_GUARD_BIT];
    assign w_sticky    = |w_frac[c_GUARD_BIT-1:0];

`ifdef INT2FP_RNE_EN
    assign w_round_up = w_guard & (w_sticky | w_man_trunc[0]);
`else
    assign w_round_up = 1'b0;
`endif

    // A carry out of the mantissa leaves it all-zero and bumps the exponent.
    assign {w_carry, w_man} = {1'b0, w_man_trunc} + {{FP32_M_WIDTH{1'b0}}, w_round_up};
    assign w_exp = FP32_E_WIDTH'(FP32_BIAS) + FP32_E_WIDTH'(r_s2.idx)
                 + FP32_E_WIDTH'(w_carry);

    always_comb begin
        w_s3_next = '0;
        if (!r_s2.zero) begin
            w_s3_next.data    = fp32_pack(r_s2.sign, w_exp, w_man);
            w_s3_next.inexact = w_guard | w_sticky;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_out       <= '0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s1        <= w_s1_next;
            r_s2_valid  <= r_s1_valid;
            r_s2        <= w_s2_next;
            r_out_valid <= r_s2_valid;
            r_out       <= w_s3_next;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out.data;
    assign out_inexact = r_out.inexact;

endmodule
`default_nettype wire

// File: tb/tb_int_to_fp32_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_to_fp32_pipe
// Brief    : Directed self-checking bench for int_to_fp32_pipe (32- and
//            64-bit instances); expectations follow INT2FP_RNE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_to_fp32_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid32, in_valid64, in_signed, out_ready;
    logic [63:0] in_data;
    logic        in_ready32, out_valid32, out_inexact32;
    logic        in_ready64, out_valid64, out_inexact64;
    logic [31:0] out_data32, out_data64;
    int          n_vec  = 0;
    int          n_miss = 0;

`ifdef INT2FP_RNE_EN
    localparam logic [31:0] c_EXP_RND_UP  = 32'h4B80_0002;
    localparam logic [31:0] c_EXP_ONES_U  = 32'h4F80_0000;
    localparam logic [31:0] c_EXP_MAXPOS  = 32'h4F00_0000;
    localparam logic [31:0] c_EXP_ONES_64 = 32'h5F80_0000;
`else
    localparam logic [31:0] c_EXP_RND_UP  = 32'h4B80_0001;
    localparam logic [31:0] c_EXP_ONES_U  = 32'h4F7F_FFFF;
    localparam logic [31:0] c_EXP_MAXPOS  = 32'h4EFF_FFFF;
    localparam logic [31:0] c_EXP_ONES_64 = 32'h5F7F_FFFF;
`endif

    always #5 clk = ~clk;

    int_to_fp32_pipe #(.INT_WIDTH(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid32),
        .in_ready    (in_ready32),
        .in_data     (in_data[31:0]),
        .in_signed   (in_signed),
        .out_valid   (out_valid32),
        .out_ready   (out_ready),
        .out_data    (out_data32),
        .out_inexact (out_inexact32)
    );

    int_to_fp32_pipe #(.INT_WIDTH(64)) u_dut64 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid64),
        .in_ready    (in_ready64),
        .in_data     (in_data),
        .in_signed   (in_signed),
        .out_valid   (out_valid64),
        .out_ready   (out_ready),
        .out_data    (out_data64),
        .out_inexact (out_inexact64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated word; result must appear exactly three cycles later.
    task automatic convert(input string tag, input bit sel64, input logic [63:0] d,
                           input logic s, input logic [31:0] ed, input logic ei);
        int          lat;
        logic        ov;
        @(posedge clk); #1;
        in_data   = d;
        in_signed = s;
        out_ready = 1'b1;
        if (sel64) in_valid64 = 1'b1;
        else       in_valid32 = 1'b1;
        lat = 0;
        ov  = 1'b0;
        while (!ov && lat < 10) begin
            @(posedge clk);
            lat++;
            if (lat == 1) begin
                #1;
                in_valid32 = 1'b0;
                in_valid64 = 1'b0;
            end
            @(negedge clk);
            ov = sel64 ? out_valid64 : out_valid32;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
        check(tag, sel64 ? out_data64 : out_data32, ed);
        check({tag, "_inexact"}, sel64 ? out_inexact64 : out_inexact32, ei);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_in  [6];
        logic        bp_sg  [6];
        logic [31:0] bp_exp [6];
        logic [31:0] prev;
        bit          have_prev;
        bit          accept;
        int          tx, rx, stale;

        rst        = 1'b1;
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
        in_data    = '0;
        in_signed  = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid32, 1'b0);
        check("rst_out_data", out_data32, 32'h0);
        check("rst_out_inexact", out_inexact32, 1'b0);
        check("rst_in_ready", in_ready32, 1'b1);
        check("rst_out_valid64", out_valid64, 1'b0);

        convert("zero",         1'b0, 64'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
        convert("one",          1'b0, 64'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0);
        convert("neg_one",      1'b0, 64'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0);
        convert("min_neg",      1'b0, 64'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0);
        convert("tie_even",     1'b0, 64'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1);
        convert("round_up",     1'b0, 64'h0100_0003, 1'b0, c_EXP_RND_UP,  1'b1);
        convert("all_ones_u",   1'b0, 64'hFFFF_FFFF, 1'b0, c_EXP_ONES_U,  1'b1);
        convert("max_pos_s",    1'b0, 64'h7FFF_FFFF, 1'b1, c_EXP_MAXPOS,  1'b1);
        convert("neg_five",     1'b0, 64'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 1'b0);
        convert("msb_unsigned", 1'b0, 64'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0);
        convert("exact_24b",    1'b0, 64'h00FF_FFFF, 1'b0, 32'h4B7F_FFFF, 1'b0);
        convert("exact_25b",    1'b0, 64'h0100_0002, 1'b0, 32'h4B80_0001, 1'b0);

        // Backpressure: six back-to-back words, output blocked in cycles 4..8.
        bp_in[0] = 32'h0000_0001; bp_sg[0] = 1'b0; bp_exp[0] = 32'h3F80_0000;
        bp_in[1] = 32'hFFFF_FFFB; bp_sg[1] = 1'b1; bp_exp[1] = 32'hC0A0_0000;
        bp_in[2] = 32'h00FF_FFFF; bp_sg[2] = 1'b0; bp_exp[2] = 32'h4B7F_FFFF;
        bp_in[3] = 32'h8000_0000; bp_sg[3] = 1'b0; bp_exp[3] = 32'h4F00_0000;
        bp_in[4] = 32'h0100_0002; bp_sg[4] = 1'b0; bp_exp[4] = 32'h4B80_0001;
        bp_in[5] = 32'h7FFF_FFFF; bp_sg[5] = 1'b1; bp_exp[5] = c_EXP_MAXPOS;
        tx = 0;
        rx = 0;
        have_prev = 1'b0;
        prev = '0;
        @(posedge clk); #1;
        in_valid32 = 1'b1;
        in_data    = 64'(bp_in[0]);
        in_signed  = bp_sg[0];
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            @(negedge clk);
            if (out_valid32 && !out_ready) begin
                check("bp_in_ready_stall", in_ready32, 1'b0);
                if (have_prev) check("bp_stable", out_data32, prev);
                prev      = out_data32;
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
            if (out_valid32 && out_ready) begin
                if (rx < 6) check($sformatf("bp_word%0d", rx), out_data32, bp_exp[rx]);
                else        check("bp_extra_word", 64'(rx), 64'd5);
                rx++;
            end
            accept = in_valid32 && in_ready32;
            @(posedge clk); #1;
            if (accept) tx++;
            if (tx < 6) begin
                in_data   = 64'(bp_in[tx]);
                in_signed = bp_sg[tx];
            end else begin
                in_valid32 = 1'b0;
            end
            if (rx >= 6 && tx >= 6) break;
        end
        check("bp_count", 64'(rx), 64'd6);
        out_ready = 1'b1;

        // Reset with three words in flight.
        @(posedge clk); #1;
        in_signed = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid32 = 1'b1;
            in_data    = 64'(32'h10 + k);
            @(posedge clk); #1;
        end
        in_valid32 = 1'b0;
        check("pre_rst_valid", out_valid32, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid32, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid32) stale++;
        end
        check("post_rst_stale", 64'(stale), 64'd0);
        convert("post_rst_neg_five", 1'b0, 64'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 1'b0);

        convert("w64_min_neg",    1'b1, 64'h8000_0000_0000_0000, 1'b1, 32'hDF00_0000, 1'b0);
        convert("w64_all_ones_u", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, c_EXP_ONES_64, 1'b1);
        convert("w64_neg_one",    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_to_fp32_pipe.md
Name: int_to_fp32_pipe

Overview:
- Pipelined converter from a parametrised-width integer (signed or unsigned, selectable per transaction) to IEEE-754 binary32.
- Generalises the existing combinational unsigned 32-bit converter:
  - negative inputs supported;
  - correct rounding when the magnitude exceeds 24 significant bits;
  - an inexact flag;
  - valid/ready flow control with full backpressure.
- Sits in the fp32 datapath ahead of the max/min and compare units.

Parameters:
- INT_WIDTH, 32, integer input width; legal range 8..64; elaboration error outside the range.
- IDX_WIDTH, $clog2(INT_WIDTH), width of the MSB-index field; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  INT_WIDTH  integer operand.
- in_signed  input  1  1 = two's-complement operand, 0 = unsigned operand.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  binary32 result {sign, exp[7:0], man[22:0]}.
- out_inexact  output  1  result differs from the exact integer value.

Behaviour:
- Reset values:
  - all stage valid bits, out_valid, out_data and out_inexact are 0;
  - in_ready is 1 in the first cycle after reset deassertion.
- Reset asserted mid-operation discards all in-flight words; nothing emerges after reset release.
- Pipeline: 3 register stages; latency 3 cycles from accepted input to out_valid while out_ready stays 1.
- Throughput: 1 word/cycle.
- Flow control:
  - global enable en = !out_valid | out_ready; in_ready = en (combinational);
  - a transfer occurs when valid & ready on the same cycle;
  - when en = 0, every stage holds its contents; no word is dropped or duplicated; order is preserved;
  - out_data and out_inexact stay stable while out_valid = 1 and out_ready = 0.
- Stage 1 (S1):
  - sign = in_signed & in_data[MSB];
  - mag = sign ? -in_data : in_data, as an INT_WIDTH-bit unsigned value;
  - the most negative value yields mag = 2^(INT_WIDTH-1), which is correct;
  - zero flag = (in_data == 0).
- Stage 2 (S2): idx = position of the highest set bit of mag, via the sub-module; mag and sign forwarded.
- Stage 3 (S3), normalise, round and pack:
  - if idx <= 23: man = (mag << (23 - idx))[22:0]; exact; inexact = 0;
  - if idx > 23: man = (mag >> (idx - 23))[22:0];
    - guard = bit idx-24; sticky = OR of bits below the guard; inexact = guard | sticky;
    - rounding is applied per the optional feature.
  - Rounding carry out of man (all ones + 1): man = 0, exp += 1.
  - exp = 127 + idx (+1 on carry). Max exp = 127 + 64 = 191, so no overflow or infinity is possible.
  - zero input: out_data = 32'h0000_0000 (never negative zero), inexact = 0.
- in_signed = 0 with MSB set is treated as a large positive value.

Optional Feature:
- Macro: INT2FP_RNE_EN.
- Defined: round-to-nearest-even; increment when guard & (sticky | man[0]).
- Undefined: truncation (round toward zero); identical mantissa to the legacy converter.
- out_inexact is reported identically in both builds.

Decomposition:
- Package int2fp_pkg:
  - FP32_E_WIDTH = 8, FP32_M_WIDTH = 23, FP32_BIAS = 127;
  - packed struct typedef fp32_t {sign, exp, man};
  - stage payload structs.
- Sub-module msb_index_detect:
  - parametric in INT_WIDTH, combinational;
  - outputs idx and a zero flag;
  - instantiated in S2;
  - reusable by later float-to-int and normalisation units.
- Top level holds the stage registers, handshake and rounding logic.

Test Plan:
- Reset then in_data = 0, in_signed = 0 -> out_data = 32'h0000_0000, inexact = 0, exactly 3 cycles after acceptance.
- in_data = 1 unsigned -> 32'h3F80_0000; in_data = 32'hFFFF_FFFF signed -> 32'hBF80_0000; in_data = 32'h8000_0000 signed -> 32'hCF00_0000, inexact = 0.
- Rounding with INT2FP_RNE_EN:
  - 32'h0100_0001 -> 32'h4B80_0000, inexact = 1 (tie to even);
  - 32'h0100_0003 -> 32'h4B80_0002;
  - 32'hFFFF_FFFF unsigned -> 32'h4F80_0000 (carry into exp).
  - Without the macro, 32'hFFFF_FFFF unsigned -> 32'h4F7F_FFFF.
- Backpressure:
  - stream 6 back-to-back words, hold out_ready = 0 for cycles 4-8;
  - expect in_ready = 0 while stalled, out_data stable, all 6 results in order, none lost or duplicated.
- Reset asserted with 3 words in flight -> out_valid = 0 immediately; no stale output after release; next word converts correctly.
- INT_WIDTH = 64 build: 64'h8000_0000_0000_0000 signed -> 32'hDF00_0000; 64'hFFFF_FFFF_FFFF_FFFF unsigned (RNE) -> 32'h5F80_0000.
